mem_access_lsu: RTL
===================

// Module: mem_access_lsu
// PURPOSE
//   MEM pipeline stage with a real load/store unit. Replaces the single-cycle, word-only MEM stage.
//   Talks to data memory over a valid/ready request channel and a valid response channel with variable latency.
//   Supports byte/half/word accesses, sign/zero extension, byte enables and misalignment detection.
//   Stalls upstream (IF/ID/EX) while an access is in flight; registers its results into MEM/WB.
// PARAMETERS
//   XLEN       32  datapath width (32 or 64); byte-enable width is XLEN/8
//   ADDR_W     32  memory address width; mem_req_addr is always XLEN/8-aligned
//   STORE_ACK  0   0: store retires on request handshake; 1: store waits for mem_rsp_valid
// PORTS
//   clk            in   1         clock
//   rst            in   1         synchronous, active-high reset
//   ex_valid       in   1         EX/MEM holds a valid instruction
//   ex_mem_read    in   1         load
//   ex_mem_write   in   1         store (never asserted together with ex_mem_read)
//   ex_funct3      in   3         size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ex_alu_result  in   XLEN      effective address, or ALU result for non-memory ops
//   ex_write_data  in   XLEN      store data, LSB-aligned
//   ex_rd          in   5         destination register
//   ex_pc_plus4    in   XLEN      PC+4 passthrough
//   ex_reg_write   in   1         passthrough control
//   ex_result_src  in   2         passthrough control
//   stall          out  1         hold EX/MEM and everything upstream (combinational)
//   mem_req_valid  out  1         request valid; held until mem_req_ready
//   mem_req_ready  in   1         memory accepts request
//   mem_req_we     out  1         1 = write
//   mem_req_addr   out  ADDR_W    aligned address (low log2(XLEN/8) bits zero)
//   mem_req_wdata  out  XLEN      store data shifted into byte lanes
//   mem_req_be     out  XLEN/8    byte enables; all ones for loads
//   mem_rsp_valid  in   1         read data / write ack valid (one cycle)
//   mem_rsp_rdata  in   XLEN      read data, full aligned word
//   mem_valid      out  1         MEM/WB holds a valid instruction
//   mem_reg_write  out  1         forced 0 on misalign
//   mem_result_src out  2         registered passthrough
//   mem_alu_result out  XLEN      registered passthrough
//   mem_read_data  out  XLEN      extracted and extended load data
//   mem_rd         out  5         registered passthrough
//   mem_pc_plus4   out  XLEN      registered passthrough
//   misalign       out  1         pulses with mem_valid for a misaligned access
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; mem_req_valid = 0 on the cycle after rst is sampled.
//   FSM IDLE -> REQ -> WAIT -> IDLE.
//     IDLE, aligned load/store on ex_valid: capture address, size, data and pass fields; go to REQ.
//       stall = 1 this cycle.
//     REQ: mem_req_valid = 1; addr, we, be and wdata stay stable until ready.
//       Load, or store with STORE_ACK = 1: on handshake go to WAIT.
//       Store with STORE_ACK = 0: on handshake go to IDLE and write MEM/WB next edge.
//       stall = !(store && !STORE_ACK && mem_req_ready).
//     WAIT: stall = !mem_rsp_valid. On mem_rsp_valid, register result into MEM/WB and go to IDLE.
//   Latency: a non-memory op, or a misaligned access, reaches mem_valid 1 cycle after ex_valid, with no stall.
//     A load accepted at cycle N with ready=1 at N+1 and rsp at cycle M has mem_valid at M+1.
//   Misaligned: H/HU with addr[0]!=0, or W with addr[1:0]!=0.
//     No memory request is issued. misalign = 1, mem_reg_write = 0, mem_valid = 1.
//   Load extract: lane = addr[log2(XLEN/8)-1:0]. B/H are sign-extended; BU/HU are zero-extended.
//   Store: wdata = write_data replicated per size into lanes. be = B: 1<<lane; H: 3<<lane; W: 4'hF<<lane.
//   mem_valid = 0 in any cycle where stall = 1 (bubble into WB).
//   mem_rsp_valid in IDLE or REQ is ignored (late response after reset). rst in REQ/WAIT drops to IDLE.
// STRUCTURE
//   Package lsu_pkg: funct3 size encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU); lsu_state_e enum.
//   Sub-module lsu_align (combinational): store lane shift + be, load extract + extend, misalign flag.
// TESTING
//   1 ALU op, alu_result=32'h1234 -> mem_valid next cycle, alu passthrough, stall never 1.
//   2 LW @0x100, ready=1, rsp 3 cycles later with rdata=32'hDEADBEEF -> stall held until rsp;
//     mem_read_data=DEADBEEF one cycle after rsp.
//   3 LB @0x103, rdata=32'h80FF_FF_FF -> 32'hFFFFFF80; LBU same -> 32'h00000080; LHU @0x102 -> 32'h000080FF.
//   4 SH @0x206, data=32'hABCD, STORE_ACK=0 -> addr=0x204, be=4'b1100, wdata=32'hABCD_xxxx lanes; ready held low 4 cycles;
//     req fields stable throughout.
//   5 LW @0x102 -> no mem_req_valid, misalign=1, mem_reg_write=0, mem_valid=1 next cycle.
//   6 rst during WAIT, then rsp_valid arrives -> state IDLE, mem_valid stays 0, late rsp ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared encodings for the MEM-stage load/store unit:
//                funct3 size/sign codes and the access state machine.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // funct3 size/sign encodings (bit 2 set = zero-extend on load)
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane logic for the load/store unit.
//                Store side: replicates store data into every lane of its
//                size and builds the byte enables. Load side: shifts the
//                addressed lane down and sign/zero extends it. Also flags
//                accesses that are not naturally aligned.
//  Ports       : funct3   - size/sign code
//                lane     - low address bits (byte offset inside the word)
//                st_data  - LSB-aligned store data
//                ld_word  - full aligned word returned by memory
//                st_wdata - store data replicated into byte lanes
//                st_be    - byte enables for the store
//                ld_data  - extracted and extended load data
//                misalign - access crosses its natural alignment
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int c_be_w   = XLEN / 8,
    localparam int c_lane_w = $clog2(c_be_w)
)(
    input  logic [2:0]          funct3,
    input  logic [c_lane_w-1:0] lane,
    input  logic [XLEN-1:0]     st_data,
    input  logic [XLEN-1:0]     ld_word,
    output logic [XLEN-1:0]     st_wdata,
    output logic [c_be_w-1:0]   st_be,
    output logic [XLEN-1:0]     ld_data,
    output logic                misalign
);

    logic [XLEN-1:0] w_shifted;
    logic            w_sign;

    always_comb begin
        // Bring the addressed lane down to bit 0 before extending.
        w_shifted = ld_word >> {lane, 3'b000};
        st_wdata  = '0;
        st_be     = '0;
        ld_data   = '0;
        misalign  = 1'b0;
        w_sign    = 1'b0;
        case (funct3)
            LSU_B, LSU_BU: begin
                for (int i = 0; i < c_be_w; i++) begin
                    st_wdata[i*8 +: 8] = st_data[7:0];
                end
                st_be         = c_be_w'(1) << lane;
                w_sign        = (funct3 == LSU_B) & w_shifted[7];
                ld_data       = {XLEN{w_sign}};
                ld_data[7:0]  = w_shifted[7:0];
            end
            LSU_H, LSU_HU: begin
                for (int i = 0; i < c_be_w / 2; i++) begin
                    st_wdata[i*16 +: 16] = st_data[15:0];
                end
                st_be         = c_be_w'(3) << lane;
                w_sign        = (funct3 == LSU_H) & w_shifted[15];
                ld_data       = {XLEN{w_sign}};
                ld_data[15:0] = w_shifted[15:0];
                misalign      = lane[0];
            end
            default: begin
                // Word access; unlisted codes are treated as a word.
                for (int i = 0; i < c_be_w / 4; i++) begin
                    st_wdata[i*32 +: 32] = st_data[31:0];
                end
                st_be         = c_be_w'(4'hF) << lane;
                w_sign        = (funct3 == LSU_W) & w_shifted[31];
                ld_data       = {XLEN{w_sign}};
                ld_data[31:0] = w_shifted[31:0];
                misalign      = |lane[1:0];
            end
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/mem_access_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_lsu
//  Description : MEM pipeline stage with a load/store unit. Issues aligned
//                requests on a valid/ready channel, waits for a variable
//                latency response, and registers the result into MEM/WB.
//                Upstream stages are held via 'stall' while an access is
//                outstanding. Misaligned accesses never reach memory; they
//                retire immediately with 'misalign' set and no reg write.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                ex_*                - EX/MEM pipeline register contents
//                stall               - hold EX/MEM and upstream
//                mem_req_*           - request channel to data memory
//                mem_rsp_*           - response channel from data memory
//                mem_*, misalign     - MEM/WB pipeline register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 32,
    parameter bit STORE_ACK = 1'b0
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic [2:0]          ex_funct3,
    input  logic [XLEN-1:0]     ex_alu_result,
    input  logic [XLEN-1:0]     ex_write_data,
    input  logic [4:0]          ex_rd,
    input  logic [XLEN-1:0]     ex_pc_plus4,
    input  logic                ex_reg_write,
    input  logic [1:0]          ex_result_src,
    output logic                stall,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_be,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata,
    output logic                mem_valid,
    output logic                mem_reg_write,
    output logic [1:0]          mem_result_src,
    output logic [XLEN-1:0]     mem_alu_result,
    output logic [XLEN-1:0]     mem_read_data,
    output logic [4:0]          mem_rd,
    output logic [XLEN-1:0]     mem_pc_plus4,
    output logic                misalign
);

    localparam int c_be_w   = XLEN / 8;
    localparam int c_lane_w = $clog2(c_be_w);

    lsu_state_e r_state;

    // Captured access (held stable for the whole request/response)
    logic [XLEN-1:0]   r_addr;
    logic [2:0]        r_funct3;
    logic              r_we;
    logic [XLEN-1:0]   r_wdata;
    logic [c_be_w-1:0] r_be;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_pc4;
    logic              r_reg_write;
    logic [1:0]        r_result_src;

    // MEM/WB register
    logic              r_mem_valid;
    logic              r_mem_reg_write;
    logic [1:0]        r_mem_result_src;
    logic [XLEN-1:0]   r_mem_alu_result;
    logic [XLEN-1:0]   r_mem_read_data;
    logic [4:0]        r_mem_rd;
    logic [XLEN-1:0]   r_mem_pc4;
    logic              r_misalign;

    logic                w_is_mem;
    logic                w_idle;
    logic                w_store_done;
    logic [2:0]          w_funct3;
    logic [c_lane_w-1:0] w_lane;
    logic [XLEN-1:0]     w_st_wdata;
    logic [c_be_w-1:0]   w_st_be;
    logic [XLEN-1:0]     w_ld_data;
    logic                w_misalign;
    logic [XLEN-1:0]     w_addr_aligned;

    assign w_is_mem = ex_mem_read | ex_mem_write;
    assign w_idle   = (r_state == ST_IDLE);

    // Fire-and-forget store completes on the request handshake itself.
    assign w_store_done = r_we & ~STORE_ACK & mem_req_ready;

    // In IDLE the aligner looks at the incoming instruction (store lanes,
    // misalign check); afterwards at the captured access (load extract).
    assign w_funct3 = w_idle ? ex_funct3 : r_funct3;
    assign w_lane   = w_idle ? ex_alu_result[c_lane_w-1:0] : r_addr[c_lane_w-1:0];

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3   (w_funct3),
        .lane     (w_lane),
        .st_data  (ex_write_data),
        .ld_word  (mem_rsp_rdata),
        .st_wdata (w_st_wdata),
        .st_be    (w_st_be),
        .ld_data  (w_ld_data),
        .misalign (w_misalign)
    );

    always_comb begin
        stall = 1'b0;
        case (r_state)
            ST_IDLE: stall = ex_valid & w_is_mem & ~w_misalign;
            ST_REQ:  stall = ~w_store_done;
            ST_WAIT: stall = ~mem_rsp_valid;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_addr           <= '0;
            r_funct3         <= '0;
            r_we             <= 1'b0;
            r_wdata          <= '0;
            r_be             <= '0;
            r_rd             <= '0;
            r_pc4            <= '0;
            r_reg_write      <= 1'b0;
            r_result_src     <= '0;
            r_mem_valid      <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_result_src <= '0;
            r_mem_alu_result <= '0;
            r_mem_read_data  <= '0;
            r_mem_rd         <= '0;
            r_mem_pc4        <= '0;
            r_misalign       <= 1'b0;
        end else begin
            // Bubble into WB unless a result retires this cycle.
            r_mem_valid <= 1'b0;
            r_misalign  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ex_valid) begin
                        if (w_is_mem && !w_misalign) begin
                            r_addr       <= ex_alu_result;
                            r_funct3     <= ex_funct3;
                            r_we         <= ex_mem_write;
                            r_wdata      <= w_st_wdata;
                            r_be         <= ex_mem_write ? w_st_be : '1;
                            r_rd         <= ex_rd;
                            r_pc4        <= ex_pc_plus4;
                            r_reg_write  <= ex_reg_write;
                            r_result_src <= ex_result_src;
                            r_state      <= ST_REQ;
                        end else begin
                            // Non-memory op or misaligned access: straight through.
                            r_mem_valid      <= 1'b1;
                            r_misalign       <= w_is_mem;
                            r_mem_reg_write  <= ex_reg_write & ~w_is_mem;
                            r_mem_result_src <= ex_result_src;
                            r_mem_alu_result <= ex_alu_result;
                            r_mem_read_data  <= '0;
                            r_mem_rd         <= ex_rd;
                            r_mem_pc4        <= ex_pc_plus4;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        if (w_store_done) begin
                            r_state          <= ST_IDLE;
                            r_mem_valid      <= 1'b1;
                            r_mem_reg_write  <= r_reg_write;
                            r_mem_result_src <= r_result_src;
                            r_mem_alu_result <= r_addr;
                            r_mem_read_data  <= '0;
                            r_mem_rd         <= r_rd;
                            r_mem_pc4        <= r_pc4;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_state          <= ST_IDLE;
                        r_mem_valid      <= 1'b1;
                        r_mem_reg_write  <= r_reg_write;
                        r_mem_result_src <= r_result_src;
                        r_mem_alu_result <= r_addr;
                        r_mem_read_data  <= r_we ? '0 : w_ld_data;
                        r_mem_rd         <= r_rd;
                        r_mem_pc4        <= r_pc4;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_addr_aligned = r_addr & ~XLEN'(c_be_w - 1);

    assign mem_req_valid  = (r_state == ST_REQ);
    assign mem_req_we     = r_we;
    assign mem_req_addr   = w_addr_aligned[ADDR_W-1:0];
    assign mem_req_wdata  = r_wdata;
    assign mem_req_be     = r_be;

    assign mem_valid      = r_mem_valid;
    assign mem_reg_write  = r_mem_reg_write;
    assign mem_result_src = r_mem_result_src;
    assign mem_alu_result = r_mem_alu_result;
    assign mem_read_data  = r_mem_read_data;
    assign mem_rd         = r_mem_rd;
    assign mem_pc_plus4   = r_mem_pc4;
    assign misalign       = r_misalign;

endmodule : mem_access_lsu
`default_nettype wire
